// File: rtl/core_boot_sequencer.sv
// Boot sequencer: receives a length-prefixed program image over UART RX, writes it
// into instruction memory, acknowledges the host and then releases the core.
module core_boot_sequencer #(
    parameter int          ADDR_W     = 14,
    parameter int          IMEM_DEPTH = 16384,
    parameter logic [7:0]  ACK_BYTE   = 8'hAA,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              core_rst,
    output logic              rx_to_core,
    output logic              loading,
    output logic              boot_err
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_ACK,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    state_t              state_q,     state_d;
    logic [1:0]          byte_idx_q,  byte_idx_d;
    logic [31:0]         word_q,      word_d;
    logic [31:0]         n_q,         n_d;
    logic [ADDR_W-1:0]   word_cnt_q,  word_cnt_d;
    logic [7:0]          tx_data_q,   tx_data_d;
    logic                tx_valid_q,  tx_valid_d;
    logic                imem_we_q,   imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_din_q,  imem_din_d;
    logic                boot_err_q,  boot_err_d;

    logic [31:0]         assembled;
    logic                word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'd0;
            n_q         <= 32'd0;
            word_cnt_q  <= '0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_din_q  <= 32'd0;
            boot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_din_q  <= imem_din_d;
            boot_err_q  <= boot_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_din_d  = imem_din_q;
        boot_err_d  = boot_err_q;

        // Little-endian merge of the incoming byte; complete once the 4th byte lands.
        assembled = word_q;
        assembled[8*byte_idx_q +: 8] = rx_data;
        word_done = rx_valid && (byte_idx_q == 2'd3);

        case (state_q)
            S_HDR: begin
                if (rx_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = assembled;
                end
                if (word_done) begin
                    if (assembled > DEPTH_W) begin
                        state_d    = S_ERR;
                        boot_err_d = 1'b1;
                        tx_data_d  = ERR_BYTE;
                        tx_valid_d = 1'b1;
                    end else if (assembled == 32'd0) begin
                        state_d    = S_ACK;
                        tx_data_d  = ACK_BYTE;
                        tx_valid_d = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        n_d        = assembled;
                        word_cnt_d = '0;
                    end
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = assembled;
                end
                if (word_done) begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = word_cnt_q;
                    imem_din_d  = assembled;
                    word_cnt_d  = word_cnt_q + 1'b1;
                    if ((32'(word_cnt_q) + 32'd1) == n_q) begin
                        state_d    = S_ACK;
                        tx_data_d  = ACK_BYTE;
                        tx_valid_d = 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_ERR: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_din   = imem_din_q;
    assign boot_err   = boot_err_q;
    assign core_rst   = (state_q != S_RUN);
    assign rx_to_core = (state_q == S_RUN);
    assign loading    = (state_q == S_HDR) || (state_q == S_LOAD);

endmodule

// File: tb/tb_core_boot_sequencer.sv
// Scenario bench for core_boot_sequencer: expected imem writes are queued as bytes are
// sent and matched (data, address and cycle) by a monitor when imem_we fires.
module tb_core_boot_sequencer;

    localparam int ADDR_W     = 14;
    localparam int IMEM_DEPTH = 16384;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic              core_rst;
    logic              rx_to_core;
    logic              loading;
    logic              boot_err;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   writes_seen = 0;
    int   cyc = 0;

    core_boot_sequencer #(
        .ADDR_W    (ADDR_W),
        .IMEM_DEPTH(IMEM_DEPTH),
        .ACK_BYTE  (8'hAA),
        .ERR_BYTE  (8'hEE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_din  (imem_din),
        .core_rst  (core_rst),
        .rx_to_core(rx_to_core),
        .loading   (loading),
        .boot_err  (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write must match the oldest queued expectation, including its due cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            writes_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: addr=%h data=%h, no write expected", imem_addr, imem_din);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (imem_addr !== e.addr || imem_din !== e.data || cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL write: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                             imem_addr, imem_din, cyc, e.addr, e.data, e.due);
                end
            end
        end
    end

    // Called at a negedge; drives one rx strobe and optionally queues the write it completes.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit push_it,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        exp_t e;
        rx_data  = b;
        rx_valid = 1'b1;
        if (push_it) begin
            e.addr = addr;
            e.data = data;
            e.due  = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_header(input logic [31:0] n);
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 0, 1'b0, '0, 32'd0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] addr, input int max_gap);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0,
                      k == 3, addr, w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b0;
    endtask

    // Waits for a tx request, optionally stalls, completes the handshake, checks release.
    task automatic finish_tx(input logic [7:0] exp_byte, input int stall, input bit exp_run);
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_timeout: tx_valid=%b after %0d cycles, required 1", tx_valid, n);
            return;
        end
        checks++;
        if (tx_data !== exp_byte) begin
            errors++;
            $display("[TB] FAIL tx_data: got %h expected %h", tx_data, exp_byte);
        end
        for (int i = 0; i < stall; i++) begin
            rx_valid = i[0];
            rx_data  = 8'($urandom);
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_byte || core_rst !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold: tx_valid=%b tx_data=%h core_rst=%b, expected 1 %h 1",
                         tx_valid, tx_data, core_rst, exp_byte);
            end
        end
        rx_valid = 1'b0;
        checks++;
        if (core_rst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_handshake_core_rst: got %b expected 1", core_rst);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || core_rst !== !exp_run || rx_to_core !== exp_run || loading !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release: tx_valid=%b core_rst=%b rx_to_core=%b loading=%b, expected 0 %b %b 0",
                     tx_valid, core_rst, rx_to_core, loading, !exp_run, exp_run);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({core_rst, rx_to_core, loading, boot_err, tx_valid, imem_we} !== 6'b101000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 101000",
                     {core_rst, rx_to_core, loading, boot_err, tx_valid, imem_we});
        end
        checks++;
        if (tx_data !== 8'h00 || imem_addr !== '0 || imem_din !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: tx_data=%h addr=%h din=%h, expected all zero", tx_data, imem_addr, imem_din);
        end
    endtask

    task automatic test_two_words();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_header(32'd2);
        checks++;
        if (loading !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_state: loading=%b tx_valid=%b, expected 1 0", loading, tx_valid);
        end
        send_word(32'h12345678, 14'd0, 0);
        send_word(32'hDEADBEEF, 14'd1, 0);
        finish_tx(8'hAA, 0, 1'b1);
        checks++;
        if (writes_seen - w0 != 2 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL two_words_count: got %0d writes (%0d pending), expected 2 (0)", writes_seen - w0, sb.size());
        end
    endtask

    task automatic test_empty();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_header(32'd0);
        finish_tx(8'hAA, 0, 1'b1);
        checks++;
        if (writes_seen != w0) begin
            errors++;
            $display("[TB] FAIL empty_writes: got %0d expected 0", writes_seen - w0);
        end
    endtask

    task automatic test_oversize();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_header(32'(IMEM_DEPTH + 1));
        checks++;
        if (boot_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boot_err: got %b expected 1", boot_err);
        end
        finish_tx(8'hEE, 3, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'(i * 17), 0, 1'b0, '0, 32'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (writes_seen != w0 || boot_err !== 1'b1 || core_rst !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_hold: writes=%0d boot_err=%b core_rst=%b tx_valid=%b, expected 0 1 1 0",
                     writes_seen - w0, boot_err, core_rst, tx_valid);
        end
    endtask

    task automatic test_full_depth_header();
        do_reset();
        send_header(32'(IMEM_DEPTH));
        repeat (2) @(negedge clk);
        checks++;
        if (loading !== 1'b1 || boot_err !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_depth_hdr: loading=%b boot_err=%b tx_valid=%b, expected 1 0 0",
                     loading, boot_err, tx_valid);
        end
    endtask

    task automatic test_backpressure();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_header(32'd1);
        send_word(32'hCAFEF00D, 14'd0, 0);
        finish_tx(8'hAA, 20, 1'b1);
        checks++;
        if (writes_seen - w0 != 1 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL backpressure_writes: got %0d expected 1", writes_seen - w0);
        end
    endtask

    task automatic test_reset_midload();
        int w0;
        do_reset();
        send_header(32'd2);
        send_word(32'h0BADF00D, 14'd0, 0);
        send_byte(8'h55, 0, 1'b0, '0, 32'd0);
        send_byte(8'h66, 0, 1'b0, '0, 32'd0);
        do_reset();
        checks++;
        if ({core_rst, rx_to_core, loading, boot_err, tx_valid, imem_we} !== 6'b101000 ||
            tx_data !== 8'h00 || imem_addr !== '0 || imem_din !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midload_reset: ctrl=%b tx_data=%h addr=%h din=%h, expected 101000 00 0 0",
                     {core_rst, rx_to_core, loading, boot_err, tx_valid, imem_we}, tx_data, imem_addr, imem_din);
        end
        w0 = writes_seen;
        send_header(32'd1);
        send_word(32'h44332211, 14'd0, 0);
        finish_tx(8'hAA, 0, 1'b1);
        checks++;
        if (writes_seen - w0 != 1 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL midload_fresh: got %0d writes expected 1", writes_seen - w0);
        end
    endtask

    task automatic test_sparse();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_header(32'd3);
        send_word(32'h12345678, 14'd0, 7);
        send_word(32'hDEADBEEF, 14'd1, 7);
        send_word($urandom, 14'd2, 7);
        finish_tx(8'hAA, 0, 1'b1);
        checks++;
        if (writes_seen - w0 != 3 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sparse_count: got %0d writes (%0d pending), expected 3 (0)", writes_seen - w0, sb.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        test_reset();
        test_two_words();
        test_empty();
        test_oversize();
        test_full_depth_header();
        test_backpressure();
        test_reset_midload();
        test_sparse();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_boot_sequencer.md
Name: core_boot_sequencer

Overview:
- Sequences core bring-up after reset.
- Receives a program image over the byte-wide UART receive stream and writes it word-by-word into instruction memory.
- Holds the pipeline in reset during loading, sends an acknowledge byte to the host, then releases the core and hands the RX stream to the core's I/O path.
- Sits between the UART RX/TX modules, the instruction-memory write port and the core's reset input.

Parameters:
- ADDR_W, 14, instruction-memory word-address width.
- IMEM_DEPTH, 16384, capacity in 32-bit words (≤ 2**ADDR_W).
- ACK_BYTE, 8'hAA, byte sent to host on successful load.
- ERR_BYTE, 8'hEE, byte sent to host on oversize image.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
- tx_ready  in  1  UART TX can accept a byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  transmit request; held until accepted.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  word address for write.
- imem_din  out  32  write data.
- core_rst  out  1  reset to riscv_pipeline.
- rx_to_core  out  1  1 = RX stream routed to core I/O.
- loading  out  1  high in HDR/LOAD.
- boot_err  out  1  sticky oversize-image error.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst.
- Reset values:
  - State HDR.
  - core_rst=1, rx_to_core=0, loading=1, boot_err=0.
  - tx_valid=0, tx_data=0, imem_we=0, imem_addr=0, imem_din=0.
  - Byte counter and word counter = 0.
- rst has priority over everything, including a mid-load transfer, a pending tx_valid, or RUN. Sequencing restarts at HDR.
- Byte assembly:
  - Little-endian: byte k of a word lands in bits [8k+7:8k].
  - A 2-bit byte index wraps 3→0 on each completed word.
- States:
  - HDR:
    - Collect 4 bytes as word count N.
    - On the 4th rx_valid, next state is chosen as follows.
    - N > IMEM_DEPTH → ERR; set boot_err, tx_data=ERR_BYTE, tx_valid=1.
    - N == 0 → ACK; tx_data=ACK_BYTE, tx_valid=1.
    - Otherwise → LOAD, word counter=0.
  - LOAD:
    - On the 4th byte of each word, the cycle after that rx_valid: imem_we=1 for exactly one cycle, imem_addr=word counter, imem_din=assembled word.
    - Word counter increments with the write. Write latency from final byte strobe = 1 cycle.
    - When the write of word N−1 issues → ACK; tx_valid=1, tx_data=ACK_BYTE set the same cycle as the last imem_we.
    - loading=1 throughout.
  - ACK:
    - tx_valid held with tx_data stable until the cycle tx_ready=1. That cycle counts as the handshake.
    - Next cycle: tx_valid=0, state RUN.
    - rx_valid in ACK is ignored.
  - RUN:
    - core_rst=0, rx_to_core=1, loading=0.
    - rx_valid ignored by this block.
    - Terminal until rst.
  - ERR:
    - Complete the ERR_BYTE handshake exactly as in ACK.
    - Then remain in ERR with core_rst=1, rx_to_core=0, loading=0, boot_err=1 until rst.
- imem_we is never asserted outside LOAD. Addresses never exceed N−1. No wrap beyond IMEM_DEPTH is possible because N is checked in HDR.
- tx_ready high before tx_valid has no effect. tx_valid is never dropped without a handshake.
- N = IMEM_DEPTH exactly is legal; the last write goes to address IMEM_DEPTH−1.
- core_rst deasserts exactly 1 cycle after the ACK handshake cycle.

Test Plan:
- Load two words: bytes 02 00 00 00, 78 56 34 12, EF BE AD DE → imem_we pulses twice, (addr 0, 32'h12345678) then (addr 1, 32'hDEADBEEF), each 1 cycle after the final byte. tx_valid with 8'hAA. After the tx_ready handshake, core_rst=0 and rx_to_core=1 next cycle.
- Empty image: 00 00 00 00 → no imem_we; ACK 8'hAA sent; core released.
- Oversize: header N=IMEM_DEPTH+1 (01 40 00 00 with defaults) → ERR_BYTE 8'hEE sent, boot_err=1, core_rst stays 1. Further bytes produce no imem_we.
- Backpressure: hold tx_ready=0 for 20 cycles in ACK → tx_valid and tx_data=8'hAA stable, core_rst=1. Raise tx_ready → release after 1 cycle. Bytes sent during the stall are ignored.
- Reset mid-load: assert rst after 2 bytes of word 1 → all outputs return to reset values. A fresh 1-word image 01 00 00 00 11 22 33 44 then writes 32'h44332211 to addr 0.
- Sparse strobes: bytes with gaps of 0–7 idle cycles between rx_valid → identical writes to the back-to-back case; exactly one imem_we per word.
